// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers ALU and LSB results in per-source FIFOs and broadcasts one per cycle on the CDB.
// Define CDB_LSB_PRIORITY_EN for fixed LSB priority instead of round-robin.
module cdb_arbiter #(
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_val,
    input  logic [DATA_W-1:0] alu_addr,
    input  logic              lsb_valid,
    output logic              lsb_ready,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_val,
    input  logic [DATA_W-1:0] lsb_addr,
    output logic              cdb_active,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_val,
    output logic [DATA_W-1:0] cdb_addr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAG_W + 2 * DATA_W;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [EW-1:0]     mem_q [2][FIFO_DEPTH];
    logic [PW-1:0]     wr_q [2], wr_d [2], rd_q [2], rd_d [2];
    logic [CW-1:0]     cnt_q [2], cnt_d [2];
    logic [EW-1:0]     in_ent [2];
    logic [EW-1:0]     head;
    logic [1:0]        in_valid, ready, push, pop, nonempty;
    logic              go, flush, gnt_lsb;
    logic              cdb_active_q, cdb_active_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_val_q, cdb_val_d, cdb_addr_q, cdb_addr_d;

    assign go       = rdy_in && !clear_in;
    assign flush    = rdy_in && clear_in;
    assign nonempty = {cnt_q[1] != '0, cnt_q[0] != '0};

`ifdef CDB_LSB_PRIORITY_EN
    assign gnt_lsb = nonempty[1];
`else
    logic rr_q, rr_d;
    // rr_q=1 prefers the LSB; it only flips when both sources compete
    assign gnt_lsb = nonempty[1] && (!nonempty[0] || rr_q);
    always_comb rr_d = (go && &nonempty) ? !rr_q : rr_q;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rr_q <= 1'b0;
        else rr_q <= rr_d;
    end
`endif

    always_comb begin
        in_ent[0] = {alu_tag, alu_val, alu_addr};
        in_ent[1] = {lsb_tag, lsb_val, lsb_addr};
        in_valid  = {lsb_valid, alu_valid};
        pop       = {go && nonempty[1] && gnt_lsb, go && nonempty[0] && !gnt_lsb};
        head      = gnt_lsb ? mem_q[1][rd_q[1]] : mem_q[0][rd_q[0]];
        ready     = '0;
        push      = '0;
        for (int s = 0; s < 2; s++) begin
            ready[s] = go && cnt_q[s] != FULL;
            // tag 0 completes the handshake but is never stored
            push[s]  = in_valid[s] && ready[s] && in_ent[s][EW-1 -: TAG_W] != '0;
            wr_d[s]  = flush ? '0 : wr_q[s] + PW'(push[s]);
            rd_d[s]  = flush ? '0 : rd_q[s] + PW'(pop[s]);
            cnt_d[s] = flush ? '0 : cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
        cdb_active_d = rdy_in ? |pop : cdb_active_q;
        {cdb_tag_d, cdb_val_d, cdb_addr_d} = |pop ? head : {cdb_tag_q, cdb_val_q, cdb_addr_q};
    end

    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++)
            if (push[s]) mem_q[s][wr_q[s]] <= in_ent[s];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < 2; s++) begin
                wr_q[s]  <= '0;
                rd_q[s]  <= '0;
                cnt_q[s] <= '0;
            end
            cdb_active_q <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_val_q    <= '0;
            cdb_addr_q   <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_q[s]  <= wr_d[s];
                rd_q[s]  <= rd_d[s];
                cnt_q[s] <= cnt_d[s];
            end
            cdb_active_q <= cdb_active_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_val_q    <= cdb_val_d;
            cdb_addr_q   <= cdb_addr_d;
        end
    end

    assign alu_ready  = ready[0];
    assign lsb_ready  = ready[1];
    assign cdb_active = cdb_active_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_val    = cdb_val_q;
    assign cdb_addr   = cdb_addr_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed checks of cdb_arbiter against a queue-based model.
module tb_cdb_arbiter;
    localparam int DEPTH = 4;

    logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b0, clear_in = 1'b0;
    logic        alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [3:0]  alu_tag = '0, lsb_tag = '0;
    logic [31:0] alu_val = '0, alu_addr = '0, lsb_val = '0, lsb_addr = '0;
    logic        alu_ready, lsb_ready, cdb_active;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val, cdb_addr;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        logic [31:0] addr;
    } ent_t;

    ent_t        aq[$], lq[$];
    bit          m_pref_lsb;
    logic        m_active;
    logic [3:0]  m_tag;
    logic [31:0] m_val, m_addr;
    int          n_tests = 0, n_fail = 0;

    cdb_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tag(alu_tag),
        .alu_val(alu_val), .alu_addr(alu_addr),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_tag(lsb_tag),
        .lsb_val(lsb_val), .lsb_addr(lsb_addr),
        .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_addr(cdb_addr)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic exp_ra();
        return rdy_in && !clear_in && aq.size() < DEPTH;
    endfunction

    function automatic logic exp_rl();
        return rdy_in && !clear_in && lq.size() < DEPTH;
    endfunction

    task automatic model_reset();
        aq.delete();
        lq.delete();
        m_pref_lsb = 0;
        m_active   = 0;
        m_tag      = '0;
        m_val      = '0;
        m_addr     = '0;
    endtask

    task automatic idle_inputs();
        alu_valid = 0;
        lsb_valid = 0;
        clear_in  = 0;
        rdy_in    = 1;
    endtask

    // One rising edge of the model, then return at the following falling edge.
    task automatic tick();
        ent_t e;
        bit ra, rl, na, nl, g_lsb;
        @(posedge clk_in);
        ra = exp_ra();
        rl = exp_rl();
        if (rdy_in) begin
            if (clear_in) begin
                aq.delete();
                lq.delete();
                m_active = 0;
            end else begin
                na = aq.size() != 0;
                nl = lq.size() != 0;
`ifdef CDB_LSB_PRIORITY_EN
                g_lsb = nl;
`else
                g_lsb = nl && (!na || m_pref_lsb);
                if (na && nl) m_pref_lsb = !m_pref_lsb;
`endif
                m_active = na || nl;
                if (m_active) begin
                    if (g_lsb) e = lq.pop_front();
                    else e = aq.pop_front();
                    m_tag  = e.tag;
                    m_val  = e.val;
                    m_addr = e.addr;
                end
                if (alu_valid && ra && alu_tag != 0) aq.push_back('{alu_tag, alu_val, alu_addr});
                if (lsb_valid && rl && lsb_tag != 0) lq.push_back('{lsb_tag, lsb_val, lsb_addr});
            end
        end
        @(negedge clk_in);
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 4 * DEPTH && (aq.size() != 0 || lq.size() != 0 || m_active); i++) begin
            tick();
            n_tests++;
            if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== {m_active, m_tag, m_val, m_addr}) begin
                n_fail++;
                $display("FAIL drain_cdb: got %h want %h", {cdb_active, cdb_tag, cdb_val, cdb_addr}, {m_active, m_tag, m_val, m_addr});
            end
        end
    endtask

    task automatic test_reset();
        rst_n_in = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk_in);
        n_tests++;
        if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_cdb: got %h want 0", {cdb_active, cdb_tag, cdb_val, cdb_addr});
        end
        rst_n_in = 1;
        #1;
        n_tests++;
        if ({alu_ready, lsb_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 11", {alu_ready, lsb_ready});
        end
        tick();
        n_tests++;
        if (cdb_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 0", cdb_active);
        end
    endtask

    task automatic test_single();
        alu_valid = 1;
        alu_tag   = 4'd3;
        alu_val   = 32'h11;
        alu_addr  = 32'h1000;
        #1;
        n_tests++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 0;
        n_tests++;
        if (cdb_active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_bypass: got %b want 0", cdb_active);
        end
        tick();
        n_tests++;
        if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== {1'b1, 4'd3, 32'h11, 32'h1000}) begin
            n_fail++;
            $display("FAIL single_bcast: got %h want %h", {cdb_active, cdb_tag, cdb_val, cdb_addr}, {1'b1, 4'd3, 32'h11, 32'h1000});
        end
        tick();
        n_tests++;
        if (cdb_active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_one_cycle: got %b want 0", cdb_active);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] obs[$];
        int first, last, cyc;
        int exp_order[8];
`ifdef CDB_LSB_PRIORITY_EN
        exp_order = '{5, 6, 7, 8, 1, 2, 3, 4};
`else
        exp_order = '{1, 5, 2, 6, 3, 7, 4, 8};
`endif
        first = -1;
        last  = -1;
        for (cyc = 0; cyc < 12; cyc++) begin
            alu_valid = cyc < 4;
            lsb_valid = cyc < 4;
            alu_tag   = 4'(cyc + 1);
            lsb_tag   = 4'(cyc + 5);
            alu_val   = $urandom;
            alu_addr  = $urandom;
            lsb_val   = $urandom;
            lsb_addr  = $urandom;
            tick();
            n_tests++;
            if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== {m_active, m_tag, m_val, m_addr}) begin
                n_fail++;
                $display("FAIL inter_cdb: got %h want %h", {cdb_active, cdb_tag, cdb_val, cdb_addr}, {m_active, m_tag, m_val, m_addr});
            end
            if (cdb_active === 1'b1) begin
                obs.push_back(cdb_tag);
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        n_tests++;
        if (obs.size() != 8 || last - first != 7) begin
            n_fail++;
            $display("FAIL inter_count: got %0d bcasts over %0d cycles want 8 over 8", obs.size(), last - first + 1);
        end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            n_tests++;
            if (obs[i] !== 4'(exp_order[i])) begin
                n_fail++;
                $display("FAIL inter_order[%0d]: got %0d want %0d", i, obs[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_full();
        int k;
        drain();
        k = 0;
        while (aq.size() < DEPTH && k < 40) begin
            alu_valid = 1;
            lsb_valid = 1;
            alu_tag   = 4'($urandom_range(1, 15));
            lsb_tag   = 4'($urandom_range(1, 15));
            alu_val   = $urandom;
            lsb_val   = $urandom;
            #1;
            n_tests++;
            if ({alu_ready, lsb_ready} !== {exp_ra(), exp_rl()}) begin
                n_fail++;
                $display("FAIL full_fill_ready: got %b want %b", {alu_ready, lsb_ready}, {exp_ra(), exp_rl()});
            end
            tick();
            k++;
        end
        alu_valid = 1;
        alu_tag   = 4'd13;
        lsb_valid = 0;
        #1;
        n_tests++;
        if (alu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b want 0", alu_ready);
        end
        tick();
        alu_valid = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_tests++;
            if (alu_ready !== exp_ra()) begin
                n_fail++;
                $display("FAIL full_recover_ready: got %b want %b", alu_ready, exp_ra());
            end
            tick();
            n_tests++;
            if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== {m_active, m_tag, m_val, m_addr}) begin
                n_fail++;
                $display("FAIL full_cdb: got %h want %h", {cdb_active, cdb_tag, cdb_val, cdb_addr}, {m_active, m_tag, m_val, m_addr});
            end
        end
    endtask

    task automatic test_tag0();
        drain();
        alu_valid = 1;
        alu_tag   = 4'd0;
        alu_val   = 32'hFF;
        #1;
        n_tests++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tag0_ready: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 0;
        repeat (4) begin
            tick();
            n_tests++;
            if (cdb_active !== 1'b0) begin
                n_fail++;
                $display("FAIL tag0_no_bcast: got %b want 0", cdb_active);
            end
        end
    endtask

    task automatic test_clear();
        drain();
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1;
            lsb_valid = 1;
            alu_tag   = 4'(i + 1);
            lsb_tag   = 4'(i + 8);
            tick();
        end
        clear_in = 1;
        alu_tag  = 4'd4;
        lsb_tag  = 4'd12;
        #1;
        n_tests++;
        if ({alu_ready, lsb_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_ready: got %b want 00", {alu_ready, lsb_ready});
        end
        tick();
        idle_inputs();
        repeat (4) begin
            n_tests++;
            if (cdb_active !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_idle: got %b want 0", cdb_active);
            end
            tick();
        end
        #1;
        n_tests++;
        if ({alu_ready, lsb_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL clear_ready_after: got %b want 11", {alu_ready, lsb_ready});
        end
    endtask

    task automatic test_hold();
        drain();
        alu_valid = 1;
        alu_tag   = 4'd9;
        alu_val   = 32'h99;
        alu_addr  = 32'h900;
        tick();
        alu_tag   = 4'd10;
        alu_val   = 32'hAA;
        alu_addr  = 32'hA00;
        tick();
        n_tests++;
        if ({cdb_active, cdb_tag, cdb_val} !== {1'b1, 4'd9, 32'h99}) begin
            n_fail++;
            $display("FAIL hold_start: got %h want %h", {cdb_active, cdb_tag, cdb_val}, {1'b1, 4'd9, 32'h99});
        end
        rdy_in  = 0;
        alu_tag = 4'd12;
        repeat (3) begin
            #1;
            n_tests++;
            if ({alu_ready, lsb_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL hold_ready: got %b want 00", {alu_ready, lsb_ready});
            end
            tick();
            n_tests++;
            if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== {1'b1, 4'd9, 32'h99, 32'h900}) begin
                n_fail++;
                $display("FAIL hold_outputs: got %h want %h", {cdb_active, cdb_tag, cdb_val, cdb_addr}, {1'b1, 4'd9, 32'h99, 32'h900});
            end
        end
        idle_inputs();
        tick();
        n_tests++;
        if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== {1'b1, 4'd10, 32'hAA, 32'hA00}) begin
            n_fail++;
            $display("FAIL hold_resume: got %h want %h", {cdb_active, cdb_tag, cdb_val, cdb_addr}, {1'b1, 4'd10, 32'hAA, 32'hA00});
        end
        tick();
        n_tests++;
        if (cdb_active !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_pause_enq: got %b want 0", cdb_active);
        end
    endtask

    task automatic test_reset_mid();
        drain();
        alu_valid = 1;
        lsb_valid = 1;
        alu_tag   = 4'd5;
        lsb_tag   = 4'd6;
        tick();
        idle_inputs();
        tick();
        #2;
        rst_n_in = 0;
        #1;
        n_tests++;
        if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== 69'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want 0", {cdb_active, cdb_tag, cdb_val, cdb_addr});
        end
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1;
        repeat (3) begin
            tick();
            n_tests++;
            if (cdb_active !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_discard: got %b want 0", cdb_active);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rdy_in    = $urandom_range(0, 9) != 0;
            clear_in  = $urandom_range(0, 39) == 0;
            alu_valid = $urandom_range(0, 2) != 0;
            lsb_valid = $urandom_range(0, 2) != 0;
            alu_tag   = 4'($urandom_range(0, 15));
            lsb_tag   = 4'($urandom_range(0, 15));
            alu_val   = $urandom;
            alu_addr  = $urandom;
            lsb_val   = $urandom;
            lsb_addr  = $urandom;
            #1;
            n_tests++;
            if ({alu_ready, lsb_ready} !== {exp_ra(), exp_rl()}) begin
                n_fail++;
                $display("FAIL rand_ready: got %b want %b", {alu_ready, lsb_ready}, {exp_ra(), exp_rl()});
            end
            tick();
            n_tests++;
            if ({cdb_active, cdb_tag, cdb_val, cdb_addr} !== {m_active, m_tag, m_val, m_addr}) begin
                n_fail++;
                $display("FAIL rand_cdb: got %h want %h", {cdb_active, cdb_tag, cdb_val, cdb_addr}, {m_active, m_tag, m_val, m_addr});
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_interleave();
        test_full();
        test_tag0();
        test_clear();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
